// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Covers the operation encoding, the FSM states and the default latencies.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 16;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit product and 32-bit quotient/remainder.
// Signed division is done on magnitudes, so INT_MIN / -1 wraps to INT_MIN with a zero remainder.
module md_compute (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mul_signed,
  input  logic        div_signed,
  output logic [63:0] prod,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // The low 64 bits of a product of sign-extended operands are the signed product.
  assign a_ext = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  assign div_zero = (b == 32'd0);
  assign a_neg    = div_signed & a[31];
  assign b_neg    = div_signed & b[31];
  assign a_mag    = a_neg ? (~a + 32'd1) : a;
  assign b_mag    = b_neg ? (~b + 32'd1) : b;
  assign b_safe   = div_zero ? 32'd1 : b_mag;

  assign q_mag = a_mag / b_safe;
  assign r_mag = a_mag % b_safe;

  // The quotient truncates toward zero; the remainder takes the sign of the dividend.
  assign quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at launch and held in pending registers until the commit edge.
//
// state  | meaning
// S_IDLE | no operation running; MTHI/MTLO and launches accepted
// S_MUL  | MULT/MULTU in flight, counting down MULT_CYCLES
// S_DIV  | DIV/DIVU in flight, counting down DIV_CYCLES
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdout
);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      p_hi;
  logic [31:0]      p_lo;
  logic             p_keep;

  logic             launch_mul;
  logic             launch_div;
  logic             wr_hi;
  logic             wr_lo;
  logic             commit;

  logic [63:0]      prod;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic             div_zero;

  md_compute u_compute (
    .a          (A),
    .b          (B),
    .mul_signed (mdop == MD_MULT),
    .div_signed (mdop == MD_DIV),
    .prod       (prod),
    .quo        (quo),
    .rem        (rem),
    .div_zero   (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    launch_mul = 1'b0;
    launch_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_mul_op(mdop)) begin
            launch_mul = 1'b1;
            state_nxt  = S_MUL;
          end else if (is_div_op(mdop)) begin
            launch_div = 1'b1;
            state_nxt  = S_DIV;
          end else if (mdop == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (mdop == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_keep <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (launch_mul) begin
        cnt    <= CNT_W'(MULT_CYCLES);
        p_hi   <= prod[63:32];
        p_lo   <= prod[31:0];
        p_keep <= 1'b0;
      end else if (launch_div) begin
        cnt    <= CNT_W'(DIV_CYCLES);
        p_hi   <= rem;
        p_lo   <= quo;
        p_keep <= div_zero;
      end else if (commit) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A divide by zero still occupies the unit but leaves HI/LO untouched.
      if (commit && !p_keep) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (wr_hi) hi <= A;
      if (wr_lo) lo <= A;
    end
  end

  assign busy      = (state != S_IDLE);
  assign stall_req = busy;

  always_comb begin
    mdout = 32'd0;
    if (mdop == MD_MFHI)      mdout = hi;
    else if (mdop == MD_MFLO) mdout = lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, divide by zero, busy blocking, async reset.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout;

  int checks;
  int errors;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdop      (mdop),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .mdout     (mdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one instruction for one cycle and returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mdop  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    mdop  = MD_NONE;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Counts busy cycles sampled at negedges, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b);
    wait_idle(n);
    chk({tag, "_cycles"}, 32'(n), 32'(cyc));
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    mdop   = MD_NONE;
    A      = 32'd0;
    B      = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);

    // Async reset during a running MULT
    issue(MD_MTHI, 32'd5, 32'd0);
    chk("mthi_hi", hi, 32'd5);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MD_MULT, 32'd3, 32'd4);
    chk("mul_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_nocommit_hi", hi, 32'd0);
    chk("arst_nocommit_lo", lo, 32'd0);
    chk("arst_nocommit_busy", {31'd0, busy}, 32'd0);

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mdop = MD_MFLO;
    #1 chk("mflo", mdout, 32'hFFFF_FFFA);
    mdop = MD_MFHI;
    #1 chk("mfhi", mdout, 32'hFFFF_FFFF);
    mdop = MD_NONE;
    #1 chk("mdout_none", mdout, 32'd0);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // Divide by zero keeps the previous HI/LO
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    chk("mtlo_lo", lo, 32'h22);
    run_op("div_zero", MD_DIV, 32'd9, 32'd0, 10, 32'h11, 32'h22);

    // Starts during busy are ignored; DIVU re-presented on the first idle cycle
    issue(MD_MULT, 32'd6, 32'd7);
    start = 1'b1;
    mdop  = MD_MTLO;
    A     = 32'hDEAD;
    #1 chk("stall_mtlo", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    mdop = MD_DIVU;
    A    = 32'd100;
    B    = 32'd7;
    #1 chk("stall_divu", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    mdop  = MD_NONE;
    chk("blocked_lo", lo, 32'h22);
    wait_idle(n);
    chk("mult_rest_cycles", 32'(n), 32'd3);
    chk("mult_keep_hi", hi, 32'd0);
    chk("mult_keep_lo", lo, 32'd42);
    run_op("divu_reissue", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
